// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared definitions for the VGA colour back-end: default
//               channel width, default sync polarity, {r,g,b} packing and
//               the blink phase encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default channel width for the 12-bit (4:4:4) RGB DAC.
  localparam int CW_DEF = 4;

  // 640x480@60 uses negative-going HS and VS pulses.
  localparam bit VGA_640X480_SYNC_POL = 1'b0;
  localparam bit SYNC_POL_DEF         = VGA_640X480_SYNC_POL;

  // Colour word layout used everywhere: r in the MSBs, b in the LSBs.
  typedef struct packed {
    logic [CW_DEF-1:0] r;
    logic [CW_DEF-1:0] g;
    logic [CW_DEF-1:0] b;
  } rgb_t;

  // PH_FORCE0 replaces the pixel's palette index with entry 0.
  typedef enum logic {
    PH_SHOW   = 1'b0,
    PH_FORCE0 = 1'b1
  } blink_phase_e;

endpackage
`default_nettype wire

// File: rtl/vga_palette_bank.sv
`default_nettype none
// ============================================================================
// Module      : vga_palette_bank
// Description : Double-buffered palette. Writes land in the shadow copy; a
//               commit strobe copies the whole shadow into the active copy
//               in one cycle when a commit is outstanding.
// Ports       : clk, reset_n        - pixel clock, async active-low reset
//               wr_en/wr_addr/wr_data - shadow write port ({r,g,b})
//               commit              - frame-edge strobe
//               rd_addr/rd_data     - combinational read of the active copy
//               wr_pending          - shadow holds uncommitted writes
// Revision    : 1.0 - initial release
// ============================================================================
module vga_palette_bank #(
  parameter int              CW    = 4,
  parameter int              SELW  = 1,
  parameter logic [3*CW-1:0] INIT0 = 12'hCA7,
  parameter logic [3*CW-1:0] INIT1 = 12'hF00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [SELW-1:0]   wr_addr,
  input  logic [3*CW-1:0]   wr_data,
  input  logic              commit,
  input  logic [SELW-1:0]   rd_addr,
  output logic [3*CW-1:0]   rd_data,
  output logic              wr_pending
);

  localparam int N  = 1 << SELW;
  localparam int DW = 3 * CW;

  logic [DW-1:0] shadow_q [N];
  logic [DW-1:0] shadow_d [N];
  logic [DW-1:0] active_q [N];
  logic [DW-1:0] active_d [N];
  logic          pending_q;
  logic          pending_d;

  function automatic logic [DW-1:0] init_val(input int idx);
    if (idx == 0)      return INIT0;
    else if (idx == 1) return INIT1;
    else               return '0;
  endfunction

  // The commit reads shadow_q, so a write in the same cycle is not part of
  // the copy; it stays in the shadow and re-arms the pending flag.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (commit && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (wr_en) begin
      shadow_d[wr_addr] = wr_data;
      pending_d         = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= init_val(i);
        active_q[i] <= init_val(i);
      end
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign rd_data    = active_q[rd_addr];
  assign wr_pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/vga_palette_mux.sv
`default_nettype none
// ============================================================================
// Module      : vga_palette_mux
// Description : Colour back-end between the VGA timing generator and the RGB
//               pins. Two-stage pipeline: S1 registers the (blink-adjusted)
//               palette index, video_on and syncs; S2 registers the looked-up
//               colour (blanked outside active video) and the delayed syncs.
//               Palette updates commit at the vertical-sync assertion edge.
// Ports       : clk, reset_n            - pixel clock, async active-low reset
//               hs_in, vs_in, video_on  - timing generator inputs
//               sel, blink_en           - pixel index, blink enable
//               wr_en/wr_addr/wr_data   - palette shadow write port
//               wr_pending              - commit outstanding
//               r, g, b, hs, vs         - registered outputs, 2-cycle latency
// Revision    : 1.0 - initial release
// ============================================================================
module vga_palette_mux
  import vga_pkg::*;
#(
  parameter int              CW           = CW_DEF,
  parameter int              SELW         = 1,
  parameter logic [3*CW-1:0] INIT0        = 12'hCA7,
  parameter logic [3*CW-1:0] INIT1        = 12'hF00,
  parameter bit              SYNC_POL     = SYNC_POL_DEF,
  parameter int              BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              video_on,
  input  logic [SELW-1:0]   sel,
  input  logic              blink_en,
  input  logic              wr_en,
  input  logic [SELW-1:0]   wr_addr,
  input  logic [3*CW-1:0]   wr_data,
  output logic              wr_pending,
  output logic [CW-1:0]     r,
  output logic [CW-1:0]     g,
  output logic [CW-1:0]     b,
  output logic              hs,
  output logic              vs
);

  localparam int              DW       = 3 * CW;
  localparam int              CNTW     = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BLINK_FRAMES - 1);

  logic [SELW-1:0] sel_s1_q, sel_s1_d;
  logic            video_on_s1_q, video_on_s1_d;
  logic            hs_s1_q, hs_s1_d;
  logic            vs_s1_q, vs_s1_d;
  logic [DW-1:0]   rgb_q, rgb_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic [CNTW-1:0] blink_cnt_q, blink_cnt_d;
  blink_phase_e    phase_q, phase_d;
  logic            vs_start;
  logic [DW-1:0]   rd_data;

  always_comb begin
    // The S1 copy of vs_in doubles as the previous-cycle value for edge
    // detection, so a held sync produces a single frame edge.
    vs_start = (vs_in == SYNC_POL) && (vs_s1_q != SYNC_POL);

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_d     = PH_SHOW;
    end else if (vs_start) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d = '0;
        phase_d     = (phase_q == PH_SHOW) ? PH_FORCE0 : PH_SHOW;
      end else begin
        blink_cnt_d = blink_cnt_q + CNTW'(1);
      end
    end

    sel_s1_d      = (phase_q == PH_FORCE0) ? '0 : sel;
    video_on_s1_d = video_on;
    hs_s1_d       = hs_in;
    vs_s1_d       = vs_in;

    // In a commit cycle rd_data is still the old palette; the new one is
    // visible from the next lookup onward.
    rgb_d = video_on_s1_q ? rd_data : '0;
    hs_d  = hs_s1_q;
    vs_d  = vs_s1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_s1_q      <= '0;
      video_on_s1_q <= 1'b0;
      hs_s1_q       <= ~SYNC_POL;
      vs_s1_q       <= ~SYNC_POL;
      rgb_q         <= '0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      blink_cnt_q   <= '0;
      phase_q       <= PH_SHOW;
    end else begin
      sel_s1_q      <= sel_s1_d;
      video_on_s1_q <= video_on_s1_d;
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
    end
  end

  vga_palette_bank #(
    .CW    (CW),
    .SELW  (SELW),
    .INIT0 (INIT0),
    .INIT1 (INIT1)
  ) u_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (vs_start),
    .rd_addr    (sel_s1_q),
    .rd_data    (rd_data),
    .wr_pending (wr_pending)
  );

  assign r  = rgb_q[DW-1:2*CW];
  assign g  = rgb_q[2*CW-1:CW];
  assign b  = rgb_q[CW-1:0];
  assign hs = hs_q;
  assign vs = vs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_palette_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_palette_mux
// Description : Bench for vga_palette_mux. Instance A (4:4:4, 2 entries,
//               active-low sync, 2-frame blink) gets directed vectors and
//               sequences; instance B (8:8:8, 8 entries, active-high sync,
//               3-frame blink) gets random traffic against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_palette_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ DUT A
  logic        rst_a_n, a_hs_in, a_vs_in, a_video_on, a_sel, a_blink_en, a_wr_en, a_wr_addr;
  logic [11:0] a_wr_data;
  logic        a_pend, a_hs, a_vs;
  logic [3:0]  a_r, a_g, a_b;
  logic [11:0] a_rgb;
  assign a_rgb = {a_r, a_g, a_b};

  vga_palette_mux #(
    .CW(4), .SELW(1), .INIT0(12'hCA7), .INIT1(12'hF00), .SYNC_POL(1'b0), .BLINK_FRAMES(2)
  ) u_dut_a (
    .clk(clk), .reset_n(rst_a_n), .hs_in(a_hs_in), .vs_in(a_vs_in), .video_on(a_video_on),
    .sel(a_sel), .blink_en(a_blink_en), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_pending(a_pend), .r(a_r), .g(a_g), .b(a_b), .hs(a_hs), .vs(a_vs)
  );

  // ------------------------------------------------------------------ DUT B
  logic        rst_b_n, b_hs_in, b_vs_in, b_video_on, b_blink_en, b_wr_en;
  logic [2:0]  b_sel, b_wr_addr;
  logic [23:0] b_wr_data;
  logic        b_pend, b_hs, b_vs;
  logic [7:0]  b_r, b_g, b_b;

  vga_palette_mux #(
    .CW(8), .SELW(3), .INIT0(24'h102030), .INIT1(24'hA0B0C0), .SYNC_POL(1'b1), .BLINK_FRAMES(3)
  ) u_dut_b (
    .clk(clk), .reset_n(rst_b_n), .hs_in(b_hs_in), .vs_in(b_vs_in), .video_on(b_video_on),
    .sel(b_sel), .blink_en(b_blink_en), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_pending(b_pend), .r(b_r), .g(b_g), .b(b_b), .hs(b_hs), .vs(b_vs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------- instance A tests
  typedef struct {
    logic        vo;
    logic        sel;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } avec_t;

  task automatic a_idle();
    a_video_on = 1'b0; a_sel = 1'b0; a_hs_in = 1'b1; a_vs_in = 1'b1; a_wr_en = 1'b0;
  endtask

  // One frame edge: sync asserted (low) for 2 cycles, then 4 idle-sync cycles.
  task automatic a_frame();
    a_vs_in = 1'b0; tick(); tick();
    a_vs_in = 1'b1; repeat (4) tick();
  endtask

  task automatic run_a();
    avec_t tv[8];
    logic [11:0] blink_exp;
    tv[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 12'hCA7};
    tv[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'hF00};
    tv[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h000};
    tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'hF00};
    tv[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
    tv[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'hCA7};
    tv[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'hF00};
    tv[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h000};

    a_idle(); a_blink_en = 1'b0; a_wr_addr = 1'b0; a_wr_data = '0; rst_a_n = 1'b0;
    repeat (2) tick();
    chk("a_reset_rgb", 32'(a_rgb), 32'h0);
    chk("a_reset_hs", 32'(a_hs), 32'h1);
    chk("a_reset_vs", 32'(a_vs), 32'h1);
    chk("a_reset_pending", 32'(a_pend), 32'h0);
    rst_a_n = 1'b1;
    tick();

    // Uncommitted write followed by a mid-stream reset.
    a_video_on = 1'b1; a_sel = 1'b1; a_hs_in = 1'b0;
    a_wr_en = 1'b1; a_wr_addr = 1'b1; a_wr_data = 12'h0F0;
    tick();
    a_wr_en = 1'b0;
    chk("a_pending_set", 32'(a_pend), 32'h1);
    tick(); tick();
    chk("a_prereset_rgb", 32'(a_rgb), 32'hF00);
    chk("a_prereset_hs", 32'(a_hs), 32'h0);
    #2 rst_a_n = 1'b0;
    #1;
    chk("a_midreset_rgb", 32'(a_rgb), 32'h0);
    chk("a_midreset_hs", 32'(a_hs), 32'h1);
    chk("a_midreset_pending", 32'(a_pend), 32'h0);
    @(negedge clk) rst_a_n = 1'b1;
    tick();

    // Vector table: outputs appear two edges after the inputs.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        a_video_on = tv[i].vo; a_sel = tv[i].sel; a_hs_in = tv[i].hs; a_vs_in = tv[i].vs;
      end else begin
        a_idle();
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("a_vec%0d_rgb", i - 1), 32'(a_rgb), 32'(tv[i-1].rgb));
        chk($sformatf("a_vec%0d_hs", i - 1), 32'(a_hs), 32'(tv[i-1].hs));
        chk($sformatf("a_vec%0d_vs", i - 1), 32'(a_vs), 32'(tv[i-1].vs));
      end
    end

    // Double buffer: write mid-frame, visible only after the vs edge.
    a_idle(); a_video_on = 1'b1; a_sel = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 1'b1; a_wr_data = 12'h0F0;
    tick();
    a_wr_en = 1'b0;
    chk("a_dbuf_pending", 32'(a_pend), 32'h1);
    tick(); tick();
    chk("a_dbuf_hold", 32'(a_rgb), 32'hF00);
    a_vs_in = 1'b0;
    tick();
    chk("a_commit_cycle_old", 32'(a_rgb), 32'hF00);
    chk("a_commit_pending_clr", 32'(a_pend), 32'h0);
    a_vs_in = 1'b1;
    tick(); tick();
    chk("a_dbuf_new", 32'(a_rgb), 32'h0F0);

    // Collision: write to entry 0 in the same cycle as a commit.
    a_wr_en = 1'b1; a_wr_addr = 1'b1; a_wr_data = 12'h00F;
    tick();
    a_vs_in = 1'b0; a_wr_addr = 1'b0; a_wr_data = 12'h123;
    tick();
    a_wr_en = 1'b0;
    chk("a_collide_pending", 32'(a_pend), 32'h1);
    a_vs_in = 1'b1; a_sel = 1'b0;
    tick(); tick();
    chk("a_collide_entry0_old", 32'(a_rgb), 32'hCA7);
    a_sel = 1'b1;
    tick(); tick();
    chk("a_collide_entry1_new", 32'(a_rgb), 32'h00F);
    a_frame();
    chk("a_collide_commit2_pend", 32'(a_pend), 32'h0);
    a_sel = 1'b0;
    tick(); tick();
    chk("a_collide_entry0_new", 32'(a_rgb), 32'h123);

    // Blink: entry1=00F, entry0=123; phase flips every 2 frame edges.
    a_sel = 1'b1; a_blink_en = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) a_frame();
      blink_exp = (((k / 2) % 2) == 1) ? 12'h123 : 12'h00F;
      chk($sformatf("a_blink_frame%0d", k), 32'(a_rgb), 32'(blink_exp));
    end
    a_blink_en = 1'b0;
    tick(); tick(); tick();
    chk("a_blink_off", 32'(a_rgb), 32'h00F);
    a_blink_en = 1'b1;
    a_frame();
    chk("a_blink_restart1", 32'(a_rgb), 32'h00F);
    a_frame();
    chk("a_blink_restart2", 32'(a_rgb), 32'h123);
    a_idle(); a_blink_en = 1'b0;
    tick();
  endtask

  // --------------------------------------------------- instance B + model
  typedef struct {
    bit       vo;
    bit [2:0] idx;
    bit       hs;
    bit       vs;
  } pix_t;

  logic [23:0] m_act [8];
  logic [23:0] m_shd [8];
  bit          m_pend;
  int          m_frames;
  bit          m_prev_vs;
  pix_t        m_pipe[$];

  task automatic b_model_reset();
    pix_t idle;
    for (int i = 0; i < 8; i++) begin
      m_act[i] = (i == 0) ? 24'h102030 : (i == 1) ? 24'hA0B0C0 : 24'h0;
      m_shd[i] = m_act[i];
    end
    m_pend = 1'b0; m_frames = 0; m_prev_vs = 1'b0;
    idle.vo = 1'b0; idle.idx = 3'd0; idle.hs = 1'b0; idle.vs = 1'b0;
    m_pipe.delete();
    m_pipe.push_back(idle);
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic b_step();
    pix_t        cur, head;
    bit          vs_start;
    logic [23:0] e_rgb;
    vs_start = b_vs_in && !m_prev_vs;
    cur.vo  = b_video_on;
    cur.idx = (((m_frames / 3) % 2) == 1) ? 3'd0 : b_sel;
    cur.hs  = b_hs_in;
    cur.vs  = b_vs_in;
    head = m_pipe.pop_front();
    m_pipe.push_back(cur);
    e_rgb = head.vo ? m_act[head.idx] : 24'h0;
    if (vs_start && m_pend) begin
      m_act  = m_shd;
      m_pend = 1'b0;
    end
    if (b_wr_en) begin
      m_shd[b_wr_addr] = b_wr_data;
      m_pend = 1'b1;
    end
    if (!b_blink_en) m_frames = 0;
    else if (vs_start) m_frames++;
    m_prev_vs = b_vs_in;
    tick();
    chk("b_rgb", 32'({b_r, b_g, b_b}), 32'(e_rgb));
    chk("b_hs", 32'(b_hs), 32'(head.hs));
    chk("b_vs", 32'(b_vs), 32'(head.vs));
    chk("b_pending", 32'(b_pend), 32'(m_pend));
  endtask

  task automatic run_b();
    b_video_on = 1'b0; b_sel = '0; b_hs_in = 1'b0; b_vs_in = 1'b0; b_blink_en = 1'b0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    rst_b_n = 1'b0;
    b_model_reset();
    repeat (2) tick();
    chk("b_reset_rgb", 32'({b_r, b_g, b_b}), 32'h0);
    chk("b_reset_hs", 32'(b_hs), 32'h0);
    chk("b_reset_vs", 32'(b_vs), 32'h0);
    rst_b_n = 1'b1;

    // Fill all 8 entries, commit on a vs edge, then sweep every index.
    for (int i = 0; i < 8; i++) begin
      b_wr_en = 1'b1; b_wr_addr = i[2:0]; b_wr_data = 24'($urandom);
      b_step();
    end
    b_wr_en = 1'b0;
    b_vs_in = 1'b1; b_step(); b_step();
    b_vs_in = 1'b0; b_step();
    b_video_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_sel = i[2:0];
      b_step();
    end
    b_video_on = 1'b0; b_step(); b_step();

    b_blink_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      b_video_on = ($urandom_range(3) != 0);
      b_sel      = 3'($urandom_range(7));
      b_hs_in    = ((c % 7) == 0);
      b_vs_in    = ((c % 37) < 3);
      b_wr_en    = ($urandom_range(4) == 0);
      b_wr_addr  = 3'($urandom_range(7));
      b_wr_data  = 24'($urandom);
      if ($urandom_range(299) == 0) b_blink_en = !b_blink_en;
      b_step();
    end
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
